gate_truth_sequencer: RTL and testbench

Self-checking controller that sequences a 2-input logic gate, such as the nand_ cell, through all four input vectors. For each vector it drives the gate inputs, waits a settle interval, samples the gate output and compares it against an expected truth table. It accumulates the observed outputs and an error count, then reports pass/fail. It sits beside a gate instance as an on-chip replacement for a hand-written stimulus sequence.

---
 rtl/gate_truth_sequencer_if.sv | 24 ++
 rtl/gate_truth_sequencer.sv | 136 +++++++++++++
 tb/tb_gate_truth_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_sequencer_if.sv
// Control, status and gate-under-test signals of the truth-table sequencer.
// master is the sequencer side; slave is the host / gate environment side.
interface gate_truth_sequencer_if;
  logic       start;
  logic       abort;
  logic       gate_a;
  logic       gate_b;
  logic       gate_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] observed;
  logic [2:0] err_count;

  modport master (
    input  start, abort, gate_y,
    output gate_a, gate_b, busy, done, pass, observed, err_count
  );

  modport slave (
    output start, abort, gate_y,
    input  gate_a, gate_b, busy, done, pass, observed, err_count
  );
endinterface

// File: rtl/gate_truth_sequencer.sv
// Walks a 2-input gate through vectors 00..11, samples its output after a settle
// interval, compares against EXPECT and reports observed bits, error count and pass.
module gate_truth_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = 4'b0111
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_truth_sequencer_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] observed_q, observed_d;
  logic [2:0] err_q, err_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gate_a_d   = gate_a_q;
    gate_b_d   = gate_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    observed_d = observed_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_SETTLE;
          idx_d      = 2'd0;
          cnt_d      = SETTLE_RELOAD;
          gate_a_d   = 1'b0;
          gate_b_d   = 1'b0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          observed_d = 4'b0000;
          err_d      = 3'd0;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          busy_d   = 1'b0;
          pass_d   = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          busy_d   = 1'b0;
          pass_d   = 1'b0;
        end else begin
          observed_d[idx_q] = bus.gate_y;
          if ((bus.gate_y != EXPECT[idx_q]) && (err_q != 3'd4))
            err_d = err_q + 3'd1;
          if (idx_q != 2'd3) begin
            state_d              = ST_SETTLE;
            idx_d                = idx_q + 2'd1;
            {gate_a_d, gate_b_d} = idx_q + 2'd1;
            cnt_d                = SETTLE_RELOAD;
          end else begin
            // Final verdict is registered on entry to DONE so it aligns with the done pulse.
            state_d  = ST_DONE;
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_d == 3'd0);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      gate_a_q   <= 1'b0;
      gate_b_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      observed_q <= 4'b0000;
      err_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gate_a_q   <= gate_a_d;
      gate_b_q   <= gate_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      observed_q <= observed_d;
      err_q      <= err_d;
    end
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.observed  = observed_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench: NAND, AND, stuck-at-1 and delayed gates, abort, ignored starts,
// back-to-back runs and synchronous reset mid-run, all against hand-computed values.
module tb_gate_truth_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mode   = 0;

  always #5 clk = ~clk;

  gate_truth_sequencer_if bus0 ();
  gate_truth_sequencer_if bus1 ();

  gate_truth_sequencer #(.SETTLE_CYCLES(2), .EXPECT(4'b0111)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  gate_truth_sequencer #(.SETTLE_CYCLES(1), .EXPECT(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Two-stage registered NAND models, one per sequencer.
  logic d0_1 = 1'b1, d0_2 = 1'b1, d1_1 = 1'b1, d1_2 = 1'b1;
  always @(posedge clk) begin
    d0_1 <= ~(bus0.gate_a & bus0.gate_b);
    d0_2 <= d0_1;
    d1_1 <= ~(bus1.gate_a & bus1.gate_b);
    d1_2 <= d1_1;
  end

  assign bus0.gate_y = (mode == 0) ? ~(bus0.gate_a & bus0.gate_b) :
                       (mode == 1) ?  (bus0.gate_a & bus0.gate_b) :
                       (mode == 2) ? 1'b1 : d0_2;
  assign bus1.gate_y = d1_2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut and wait (bounded) for done; cyc = edges from accept to done.
  task automatic run0(output int cyc);
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    cyc = 0;
    while (bus0.done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
    checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", bus0.pass); end
    checks++; if ({bus0.gate_a, bus0.gate_b} !== 2'b00) begin errors++; $display("FAIL reset_gates got=%b%b exp=00", bus0.gate_a, bus0.gate_b); end
    checks++; if (bus0.observed !== 4'b0000) begin errors++; $display("FAIL reset_observed got=%b exp=0000", bus0.observed); end
    checks++; if (bus0.err_count !== 3'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", bus0.err_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_nand();
    int busy_n;
    int done_k;
    bit order_ok;
    mode = 0;
    busy_n = 0; done_k = -1; order_ok = 1'b1;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      if (bus0.busy === 1'b1) busy_n++;
      if (bus0.done === 1'b1 && done_k < 0) done_k = k;
      if (k % 3 == 0 && k < 12 && {bus0.gate_a, bus0.gate_b} !== 2'(k / 3)) order_ok = 1'b0;
    end
    checks++; if (busy_n != 12) begin errors++; $display("FAIL nand_busy_cycles got=%0d exp=12", busy_n); end
    checks++; if (done_k != 12) begin errors++; $display("FAIL nand_done_latency got=%0d exp=12", done_k); end
    checks++; if (!order_ok) begin errors++; $display("FAIL nand_vector_order got=bad exp=00,01,10,11"); end
    checks++; if (bus0.observed !== 4'b0111) begin errors++; $display("FAIL nand_observed got=%b exp=0111", bus0.observed); end
    checks++; if (bus0.err_count !== 3'd0) begin errors++; $display("FAIL nand_err got=%0d exp=0", bus0.err_count); end
    checks++; if (bus0.pass !== 1'b1) begin errors++; $display("FAIL nand_pass got=%b exp=1", bus0.pass); end
    step();
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL nand_done_pulse got=%b exp=0", bus0.done); end
    checks++; if (bus0.pass !== 1'b1) begin errors++; $display("FAIL nand_pass_held got=%b exp=1", bus0.pass); end
    step();
  endtask

  task automatic test_and();
    int cyc;
    mode = 1;
    run0(cyc);
    checks++; if (cyc != 12) begin errors++; $display("FAIL and_latency got=%0d exp=12", cyc); end
    checks++; if (bus0.observed !== 4'b1000) begin errors++; $display("FAIL and_observed got=%b exp=1000", bus0.observed); end
    checks++; if (bus0.err_count !== 3'd4) begin errors++; $display("FAIL and_err got=%0d exp=4", bus0.err_count); end
    checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL and_pass got=%b exp=0", bus0.pass); end
    step();
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL and_single_done got=%b exp=0", bus0.done); end
    step();
  endtask

  task automatic test_stuck1();
    int cyc;
    mode = 2;
    run0(cyc);
    checks++; if (cyc != 12) begin errors++; $display("FAIL stuck_latency got=%0d exp=12", cyc); end
    checks++; if (bus0.observed !== 4'b1111) begin errors++; $display("FAIL stuck_observed got=%b exp=1111", bus0.observed); end
    checks++; if (bus0.err_count !== 3'd1) begin errors++; $display("FAIL stuck_err got=%0d exp=1", bus0.err_count); end
    checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got=%b exp=0", bus0.pass); end
    repeat (2) step();
  endtask

  task automatic test_delay();
    int cyc;
    mode = 3;
    run0(cyc);
    checks++; if (bus0.pass !== 1'b1) begin errors++; $display("FAIL delay2_pass got=%b exp=1", bus0.pass); end
    checks++; if (bus0.observed !== 4'b0111) begin errors++; $display("FAIL delay2_observed got=%b exp=0111", bus0.observed); end
    repeat (2) step();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    cyc = 0;
    while (bus1.done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    checks++; if (cyc != 8) begin errors++; $display("FAIL delay1_latency got=%0d exp=8", cyc); end
    checks++; if (bus1.pass !== 1'b0) begin errors++; $display("FAIL delay1_pass got=%b exp=0", bus1.pass); end
    checks++; if (bus1.err_count !== 3'd1) begin errors++; $display("FAIL delay1_err got=%0d exp=1", bus1.err_count); end
    checks++; if (bus1.observed !== 4'b1111) begin errors++; $display("FAIL delay1_observed got=%b exp=1111", bus1.observed); end
    repeat (2) step();
    mode = 0;
  endtask

  task automatic test_abort();
    int dones;
    int cyc;
    mode = 0;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    repeat (6) step();
    checks++; if ({bus0.gate_a, bus0.gate_b} !== 2'b10) begin errors++; $display("FAIL abort_pre_vector got=%b%b exp=10", bus0.gate_a, bus0.gate_b); end
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus0.busy); end
    checks++; if ({bus0.gate_a, bus0.gate_b} !== 2'b00) begin errors++; $display("FAIL abort_gates got=%b%b exp=00", bus0.gate_a, bus0.gate_b); end
    checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL abort_pass got=%b exp=0", bus0.pass); end
    checks++; if (bus0.observed !== 4'b0011) begin errors++; $display("FAIL abort_observed got=%b exp=0011", bus0.observed); end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus0.done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    run0(cyc);
    checks++; if (bus0.pass !== 1'b1) begin errors++; $display("FAIL abort_rerun_pass got=%b exp=1", bus0.pass); end
    checks++; if (bus0.err_count !== 3'd0) begin errors++; $display("FAIL abort_rerun_err got=%0d exp=0", bus0.err_count); end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    int dones;
    int first_k;
    int second_k;
    mode = 0;
    dones = 0;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      bus0.start = (k == 4 || k == 12) ? 1'b1 : 1'b0;
      step();
      if (bus0.done === 1'b1) dones++;
    end
    bus0.start = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL ignored_start_dones got=%0d exp=1", dones); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_not_queued got=%b exp=0", bus0.busy); end
    first_k = -1; second_k = -1;
    bus0.start = 1'b1;
    step();
    for (int k = 1; k <= 26; k++) begin
      step();
      if (bus0.done === 1'b1) begin
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
    end
    bus0.start = 1'b0;
    checks++; if (first_k != 12) begin errors++; $display("FAIL held_first_done got=%0d exp=12", first_k); end
    checks++; if (second_k != 26) begin errors++; $display("FAIL held_second_done got=%0d exp=26", second_k); end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int busy_n;
    mode = 1;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    bus0.start = 1'b1;
    step();
    rst = 1'b0;
    bus0.start = 1'b0;
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus0.busy); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus0.done); end
    checks++; if (bus0.pass !== 1'b0) begin errors++; $display("FAIL midrst_pass got=%b exp=0", bus0.pass); end
    checks++; if ({bus0.gate_a, bus0.gate_b} !== 2'b00) begin errors++; $display("FAIL midrst_gates got=%b%b exp=00", bus0.gate_a, bus0.gate_b); end
    checks++; if (bus0.observed !== 4'b0000) begin errors++; $display("FAIL midrst_observed got=%b exp=0000", bus0.observed); end
    checks++; if (bus0.err_count !== 3'd0) begin errors++; $display("FAIL midrst_err got=%0d exp=0", bus0.err_count); end
    busy_n = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus0.busy === 1'b1 || bus0.done === 1'b1) busy_n++;
    end
    checks++; if (busy_n != 0) begin errors++; $display("FAIL midrst_stays_idle got=%0d exp=0", busy_n); end
  endtask

  initial begin
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    test_reset();
    test_nand();
    test_and();
    test_stuck1();
    test_delay();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
